// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_pkg
// Description : Shared widths and signed sample/coefficient/accumulator types
//               for the transposed-FIR tap pipeline.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

  localparam int WIDTH_DATA  = 24;
  localparam int WIDTH_COEFF = 16;
  // The full signed product of data and coefficient fits in their summed width.
  localparam int WIDTH_REG   = WIDTH_DATA + WIDTH_COEFF;

  typedef logic signed [WIDTH_DATA-1:0]  sample_t;
  typedef logic signed [WIDTH_COEFF-1:0] coeff_t;
  typedef logic signed [WIDTH_REG-1:0]   acc_t;

endpackage : fir_pkg
`default_nettype wire

// File: rtl/dff_w.sv
`default_nettype none
// ============================================================================
// Module      : dff_w
// Description : Parameterised register bank with asynchronous active-low clear.
// Ports       : clk   - clock, captures on rising edge
//               rst_n - asynchronous active-low reset, clears q_out to 0
//               d_in  - next-state value
//               q_out - registered value
// Revision    : 1.0 - initial release
// ============================================================================
module dff_w #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_out
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_out <= '0;
    end else begin
      q_out <= d_in;
    end
  end

endmodule : dff_w
`default_nettype wire

// File: rtl/multi_dff_pipe.sv
`default_nettype none
// ============================================================================
// Module      : multi_dff_pipe
// Description : One tap of a transposed FIR: register sample, multiply by a
//               static coefficient, register product, add incoming partial
//               sum and register the result for the next tap.
// Ports       : clk     - clock
//               rst_n   - asynchronous active-low reset
//               d_in    - signed sample in
//               coeff   - signed tap coefficient (static)
//               acc_in  - signed partial sum from previous tap (0 for tap 0)
//               q_data  - registered sample
//               mul_out - combinational full-precision product q_data*coeff
//               q_prod  - registered product
//               sum_out - combinational wrapping sum q_prod+acc_in
//               sum_q   - registered sum, drives acc_in of the next tap
// Revision    : 1.0 - initial release
// ============================================================================
module multi_dff_pipe #(
  parameter int WIDTH_DATA  = fir_pkg::WIDTH_DATA,
  parameter int WIDTH_COEFF = fir_pkg::WIDTH_COEFF,
  parameter int WIDTH_REG   = WIDTH_DATA + WIDTH_COEFF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic signed [WIDTH_DATA-1:0]  d_in,
  input  logic signed [WIDTH_COEFF-1:0] coeff,
  input  logic signed [WIDTH_REG-1:0]   acc_in,
  output logic signed [WIDTH_DATA-1:0]  q_data,
  output logic signed [WIDTH_REG-1:0]   mul_out,
  output logic signed [WIDTH_REG-1:0]   q_prod,
  output logic signed [WIDTH_REG-1:0]   sum_out,
  output logic signed [WIDTH_REG-1:0]   sum_q
);

  import fir_pkg::*;

  logic signed [WIDTH_REG-1:0] data_ext_d;
  logic signed [WIDTH_REG-1:0] coeff_ext_d;

  // Widen both operands with sign extension before multiplying so the product
  // is computed at full precision; the result never exceeds WIDTH_REG bits.
  assign data_ext_d  = WIDTH_REG'(q_data);
  assign coeff_ext_d = WIDTH_REG'(coeff);
  assign mul_out     = data_ext_d * coeff_ext_d;

  // Plain two's-complement add: overflow wraps, no saturation.
  assign sum_out     = q_prod + acc_in;

  dff_w #(.WIDTH(WIDTH_DATA)) u_data_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .d_in  (d_in),
    .q_out (q_data)
  );

  dff_w #(.WIDTH(WIDTH_REG)) u_prod_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .d_in  (mul_out),
    .q_out (q_prod)
  );

  dff_w #(.WIDTH(WIDTH_REG)) u_sum_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .d_in  (sum_out),
    .q_out (sum_q)
  );

endmodule : multi_dff_pipe
`default_nettype wire

// File: tb/tb_multi_dff_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_dff_pipe
// Description : Self-checking bench for one FIR tap pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_dff_pipe;
  import fir_pkg::*;

  logic    clk;
  logic    rst_n;
  sample_t d_in;
  coeff_t  coeff;
  acc_t    acc_in;
  sample_t q_data;
  acc_t    mul_out;
  acc_t    q_prod;
  acc_t    sum_out;
  acc_t    sum_q;

  int checks = 0;
  int errors = 0;

  multi_dff_pipe dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_in    (d_in),
    .coeff   (coeff),
    .acc_in  (acc_in),
    .q_data  (q_data),
    .mul_out (mul_out),
    .q_prod  (q_prod),
    .sum_out (sum_out),
    .sum_q   (sum_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic acc_t model_prod(input sample_t d, input coeff_t c);
    longint a;
    longint b;
    longint p;
    a = d;
    b = c;
    p = a * b;
    return p[WIDTH_REG-1:0];
  endfunction

  acc_t    prod_q[$];
  acc_t    exp_prod;
  acc_t    last_prod;
  acc_t    exp_sum;
  sample_t rnd_d;

  initial begin
    rst_n  = 1'b1;
    d_in   = 24'h123456;
    coeff  = 16'h0005;
    acc_in = 40'h0000001234;

    // Reset with nonzero inputs, checked between edges.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_q_data",  {40'd0, q_data}, 64'd0);
    chk("rst_q_prod",  {24'd0, q_prod}, 64'd0);
    chk("rst_sum_q",   {24'd0, sum_q},  64'd0);
    chk("rst_mul_out", {24'd0, mul_out}, 64'd0);
    chk("rst_sum_out", {24'd0, sum_out}, {24'd0, acc_in});

    // 3 * 5 through the pipeline.
    d_in   = 24'h000003;
    acc_in = '0;
    #1 rst_n = 1'b1;
    tick();
    chk("basic_q_data",  {40'd0, q_data}, 64'd3);
    chk("basic_mul_out", {24'd0, mul_out}, 64'h0F);
    tick();
    chk("basic_q_prod",  {24'd0, q_prod}, 64'h0F);
    chk("basic_sum_out", {24'd0, sum_out}, 64'h0F);
    tick();
    chk("basic_sum_q",   {24'd0, sum_q}, 64'h0F);

    // -1 * 0x7FFF
    d_in  = 24'hFFFFFF;
    coeff = 16'h7FFF;
    tick();
    chk("neg_mul_out", {24'd0, mul_out}, 64'hFF_FFFF_8001);

    // Most-negative corner: -2^23 * -2^15 = 2^38
    d_in  = 24'h800000;
    coeff = 16'h8000;
    tick();
    chk("corner_mul_out", {24'd0, mul_out}, 64'h40_0000_0000);
    tick();
    chk("corner_q_prod", {24'd0, q_prod}, 64'h40_0000_0000);

    // Accumulator wrap: 1 + 0x7FFFFFFFFF
    d_in  = 24'h000001;
    coeff = 16'h0001;
    tick();
    tick();
    chk("wrap_q_prod", {24'd0, q_prod}, 64'h1);
    acc_in = 40'h7F_FFFF_FFFF;
    #1;
    chk("wrap_sum_out", {24'd0, sum_out}, 64'h80_0000_0000);
    tick();
    chk("wrap_sum_q", {24'd0, sum_q}, 64'h80_0000_0000);

    // Streaming with a scoreboard: product expected 2 edges after drive,
    // registered sum expected 1 edge after acc_in is presented.
    coeff     = 16'($urandom_range(0, 16'hFFFF));
    acc_in    = '0;
    last_prod = '0;
    prod_q    = {};
    // Flush the pipe so q_prod starts from a known product.
    d_in = '0;
    tick();
    tick();
    for (int i = 0; i < 20; i++) begin
      rnd_d  = 24'($urandom);
      d_in   = rnd_d;
      acc_in = {8'($urandom), 32'($urandom)};
      prod_q.push_back(model_prod(rnd_d, coeff));
      exp_sum = last_prod + acc_in;
      tick();
      chk("stream_q_data", {40'd0, q_data}, {40'd0, rnd_d});
      if (i >= 1) begin
        exp_prod  = prod_q.pop_front();
        last_prod = exp_prod;
        chk("stream_q_prod", {24'd0, q_prod}, {24'd0, exp_prod});
      end
      chk("stream_sum_q", {24'd0, sum_q}, {24'd0, exp_sum});
    end

    // Mid-stream reset between edges discards everything in flight.
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_q_data", {40'd0, q_data}, 64'd0);
    chk("mid_rst_q_prod", {24'd0, q_prod}, 64'd0);
    chk("mid_rst_sum_q",  {24'd0, sum_q},  64'd0);
    d_in   = 24'h000007;
    coeff  = 16'h0003;
    acc_in = '0;
    #1 rst_n = 1'b1;
    tick();
    chk("post_rst_q_data", {40'd0, q_data}, 64'd7);
    chk("post_rst_q_prod", {24'd0, q_prod}, 64'd0);
    d_in = '0;
    tick();
    chk("post_rst_q_prod2", {24'd0, q_prod}, 64'd21);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_multi_dff_pipe
`default_nettype wire

// File: doc/multi_dff_pipe.md
MULTI_DFF_PIPE -- requirements
Module: multi_dff_pipe

Interface
REQ-001 Parameter WIDTH_DATA, default 24, SHALL set the signed sample width.
REQ-002 Parameter WIDTH_COEFF, default 16, SHALL set the signed coefficient width.
REQ-003 Parameter WIDTH_REG, default WIDTH_DATA+WIDTH_COEFF (40), SHALL set the product and accumulator width.
REQ-004 clk  input  1  SHALL be the single clock; all registers update on its rising edge.
REQ-005 rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-006 d_in  input  WIDTH_DATA  SHALL carry the signed sample into the data register.
REQ-007 coeff  input  WIDTH_COEFF  SHALL carry the signed tap coefficient; it is static during operation.
REQ-008 acc_in  input  WIDTH_REG  SHALL carry the signed partial sum from the previous tap; it is 0 for the first tap.
REQ-009 q_data  output  WIDTH_DATA  SHALL be the registered sample.
REQ-010 mul_out  output  WIDTH_REG  SHALL be the combinational signed product q_data*coeff.
REQ-011 q_prod  output  WIDTH_REG  SHALL be the registered product.
REQ-012 sum_out  output  WIDTH_REG  SHALL be the combinational sum q_prod+acc_in.
REQ-013 sum_q  output  WIDTH_REG  SHALL be the registered sum, which feeds acc_in of the next tap.

Function
REQ-014 q_data SHALL take d_in on each rising clk edge (latency 1).
REQ-015 mul_out SHALL be the full-precision signed product: q_data sign-extended to WIDTH_REG times coeff sign-extended to WIDTH_REG, with no truncation or rounding.
REQ-016 q_prod SHALL take mul_out on each rising edge, so d_in reaches q_prod after 2 edges.
REQ-017 sum_out SHALL be the signed sum q_prod+acc_in, wrapping modulo 2^WIDTH_REG with no saturation.
REQ-018 sum_q SHALL take sum_out on each rising edge.
REQ-019 There SHALL be no handshake or enable: the block accepts one sample every cycle.
REQ-020 Corner case -8388608 * -32768 = 2^38 SHALL fit in the product without overflow.

Reset
REQ-021 While rst_n=0, q_data, q_prod and sum_q SHALL clear to 0 immediately, without waiting for clk.
REQ-022 During reset, mul_out SHALL be 0 and sum_out SHALL equal acc_in, both following combinationally from the cleared registers.
REQ-023 After rst_n rises, capture SHALL resume on the first rising edge.
REQ-024 Reset asserted mid-stream SHALL discard all in-flight samples.

Structure
REQ-025 WIDTH_DATA, WIDTH_COEFF, WIDTH_REG and their signed sample, coefficient and accumulator types SHALL live in a shared package, fir_pkg.
REQ-026 One parameterised register sub-module, dff_w (WIDTH parameter; ports clk, rst_n, d_in, q_out), SHALL implement all three registers.
REQ-027 The multiplier and adder SHALL be inline combinational logic.
REQ-028 A TAP-long chain of this block, with acc_in of tap 0 tied to 0, SHALL form a transposed FIR; chaining SHALL require no extra logic.

Verification
REQ-029 Assert rst_n=0 with nonzero inputs -> q_data, q_prod, sum_q = 0 immediately; sum_out = acc_in.
REQ-030 d_in=0x000003, coeff=0x0005 -> after edge 1, q_data=3 and mul_out=0x000000000F; after edge 2, q_prod=0x000000000F.
REQ-031 d_in=0xFFFFFF (-1), coeff=0x7FFF -> mul_out=0xFFFFFF8001 (-32767).
REQ-032 d_in=0x800000, coeff=0x8000 -> mul_out=0x4000000000.
REQ-033 q_prod=1, acc_in=0x7FFFFFFFFF -> sum_out=0x8000000000 (wrap); sum_q takes that value on the next edge.
REQ-034 Deassert rst_n between edges in mid-stream -> all registers read 0 before the next edge, and a fresh sample reaches q_prod 2 edges after release.
